// File: rtl/loop_counter_pkg.sv
// Shared types for the nested loop counter.
package loop_counter_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } lc_state_e;

endpackage : loop_counter_pkg

// File: rtl/loop_counter_dim.sv
// One dimension of the nested loop counter: counter, loadable maximum, carry chain and position flags.
module loop_counter_dim #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_cnt,
    input  logic             load_max,
    input  logic [WIDTH-1:0] max_in,
    input  logic             carry_in,
    output logic [WIDTH-1:0] count,
    output logic             carry_out,
    output logic             dim_start,
    output logic             dim_last,
    output logic             dim_end
);

    logic [WIDTH-1:0] max_q;

    // Maximum register: reloaded only when the controller allows it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_q <= '1;
        end else if (load_max) begin
            max_q <= max_in;
        end
    end

    // Counter: cleared on request, otherwise advances (or wraps at max) when the carry reaches it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr_cnt) begin
            count <= '0;
        end else if (carry_in) begin
            count <= dim_end ? '0 : count + WIDTH'(1);
        end
    end

    // Position flags and carry to the next slower dimension.
    always_comb begin
        dim_start = (count == '0);
        dim_last  = (count == WIDTH'(max_q - WIDTH'(1)));
        dim_end   = (count == max_q);
        carry_out = carry_in & dim_end;
    end

endmodule : loop_counter_dim

// File: rtl/loop_counter.sv
// Nested odometer-style loop counter with start/done sequencing in one-shot or continuous mode.
module loop_counter
    import loop_counter_pkg::*;
#(
    parameter int unsigned NDIM  = 3,
    parameter int unsigned WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  load_max,
    input  logic [NDIM*WIDTH-1:0] max_count,
    input  logic                  continuous,
    input  logic                  start,
    input  logic                  step,
    output logic [NDIM*WIDTH-1:0] counter,
    output logic [NDIM-1:0]       dim_start,
    output logic [NDIM-1:0]       dim_last,
    output logic [NDIM-1:0]       dim_end,
    output logic                  all_end,
    output logic                  busy,
    output logic                  done
);

    lc_state_e state_q, state_d;
    logic      cont_q, cont_d;
    logic      done_q, done_d;
    logic      idle;
    logic      clr_cnt;
    logic      load_en;
    logic      final_step;
    logic [NDIM:0] carry;

    // Counter clear/load qualification; load and start only matter while idle, clr always wins.
    always_comb begin
        idle     = (state_q == IDLE);
        clr_cnt  = clr | (idle & (load_max | start));
        load_en  = ~clr & idle & load_max;
        carry[0] = ~clr & ~idle & step;
    end

    genvar k;
    generate
        for (k = 0; k < int'(NDIM); k++) begin : g_dim
            loop_counter_dim #(
                .WIDTH(WIDTH)
            ) u_dim (
                .clk      (clk),
                .rst      (rst),
                .clr_cnt  (clr_cnt),
                .load_max (load_en),
                .max_in   (max_count[k*WIDTH +: WIDTH]),
                .carry_in (carry[k]),
                .count    (counter[k*WIDTH +: WIDTH]),
                .carry_out(carry[k+1]),
                .dim_start(dim_start[k]),
                .dim_last (dim_last[k]),
                .dim_end  (dim_end[k])
            );
        end
    endgenerate

    // The carry leaving the slowest dimension marks the final step of an iteration.
    always_comb begin
        all_end    = &dim_end;
        final_step = carry[NDIM];
    end

    // FSM state, latched mode and done pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cont_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cont_q  <= cont_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: start enters RUN, final step ends a one-shot run, clr aborts silently.
    always_comb begin
        state_d = state_q;
        cont_d  = cont_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!clr && !load_max && start) begin
                    state_d = RUN;
                    cont_d  = continuous;
                end
            end
            RUN: begin
                if (clr) begin
                    state_d = IDLE;
                end else if (final_step) begin
                    done_d = 1'b1;
                    if (!cont_q) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status outputs straight from the registers.
    always_comb begin
        busy = (state_q == RUN);
        done = done_q;
    end

endmodule : loop_counter

// File: tb/tb_loop_counter.sv
// Self-checking bench for loop_counter with NDIM=3, WIDTH=4.
module tb_loop_counter;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        load_max;
    logic [11:0] max_count;
    logic        continuous;
    logic        start;
    logic        step;
    logic [11:0] counter;
    logic [2:0]  dim_start;
    logic [2:0]  dim_last;
    logic [2:0]  dim_end;
    logic        all_end;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        clr;
        logic        ld;
        logic        start;
        logic        cont;
        logic        step;
        logic [11:0] maxc;
        logic [11:0] cnt;
        logic        busy;
        logic        done;
        logic [2:0]  dend;
    } vec_t;

    vec_t tbl[$];

    loop_counter #(.NDIM(3), .WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .load_max  (load_max),
        .max_count (max_count),
        .continuous(continuous),
        .start     (start),
        .step      (step),
        .counter   (counter),
        .dim_start (dim_start),
        .dim_last  (dim_last),
        .dim_end   (dim_end),
        .all_end   (all_end),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic c, input logic l, input logic s, input logic m,
                                input logic st, input logic [11:0] mx, input logic [11:0] cn,
                                input logic b, input logic d, input logic [2:0] de);
        vec_t v;
        v.clr = c; v.ld = l; v.start = s; v.cont = m; v.step = st;
        v.maxc = mx; v.cnt = cn; v.busy = b; v.done = d; v.dend = de;
        return v;
    endfunction

    initial begin
        logic [11:0] exp_cnt;
        int d0, d1, d2;

        // Continuous mode, max {1,1,1}, step toggling, then clr on what would be a final step.
        tbl.push_back(mk(0,1,0,0,0, 12'h111, 12'h000, 0,0, 3'b000));
        tbl.push_back(mk(0,0,1,1,0, 12'h111, 12'h000, 1,0, 3'b000));
        tbl.push_back(mk(0,0,0,0,1, 12'h111, 12'h001, 1,0, 3'b001));
        tbl.push_back(mk(0,0,0,0,0, 12'h111, 12'h001, 1,0, 3'b001));
        tbl.push_back(mk(0,0,0,0,1, 12'h111, 12'h010, 1,0, 3'b010));
        tbl.push_back(mk(0,0,0,0,0, 12'h111, 12'h010, 1,0, 3'b010));
        tbl.push_back(mk(0,0,0,0,1, 12'h111, 12'h011, 1,0, 3'b011));
        tbl.push_back(mk(0,0,0,0,0, 12'h111, 12'h011, 1,0, 3'b011));
        tbl.push_back(mk(0,0,0,0,1, 12'h111, 12'h100, 1,0, 3'b100));
        tbl.push_back(mk(0,0,0,0,0, 12'h111, 12'h100, 1,0, 3'b100));
        tbl.push_back(mk(0,0,0,0,1, 12'h111, 12'h101, 1,0, 3'b101));
        tbl.push_back(mk(0,0,0,0,0, 12'h111, 12'h101, 1,0, 3'b101));
        tbl.push_back(mk(0,0,0,0,1, 12'h111, 12'h110, 1,0, 3'b110));
        tbl.push_back(mk(0,0,0,0,0, 12'h111, 12'h110, 1,0, 3'b110));
        tbl.push_back(mk(0,0,0,0,1, 12'h111, 12'h111, 1,0, 3'b111));
        tbl.push_back(mk(0,0,0,0,0, 12'h111, 12'h111, 1,0, 3'b111));
        tbl.push_back(mk(0,0,0,0,1, 12'h111, 12'h000, 1,1, 3'b000));
        tbl.push_back(mk(0,0,0,0,0, 12'h111, 12'h000, 1,0, 3'b000));
        tbl.push_back(mk(0,0,0,0,1, 12'h111, 12'h001, 1,0, 3'b001));
        tbl.push_back(mk(0,0,0,0,1, 12'h111, 12'h010, 1,0, 3'b010));
        tbl.push_back(mk(0,0,0,0,1, 12'h111, 12'h011, 1,0, 3'b011));
        tbl.push_back(mk(0,0,0,0,1, 12'h111, 12'h100, 1,0, 3'b100));
        tbl.push_back(mk(0,0,0,0,1, 12'h111, 12'h101, 1,0, 3'b101));
        tbl.push_back(mk(0,0,0,0,1, 12'h111, 12'h110, 1,0, 3'b110));
        tbl.push_back(mk(0,0,0,0,1, 12'h111, 12'h111, 1,0, 3'b111));
        tbl.push_back(mk(1,0,0,0,1, 12'h111, 12'h000, 0,0, 3'b000));
        tbl.push_back(mk(0,0,0,0,1, 12'h111, 12'h000, 0,0, 3'b000));
        // Zero maxima on dims 0 and 2, max {0,2,0}, one-shot.
        tbl.push_back(mk(0,1,0,0,0, 12'h020, 12'h000, 0,0, 3'b101));
        tbl.push_back(mk(0,0,1,0,0, 12'h020, 12'h000, 1,0, 3'b101));
        tbl.push_back(mk(0,0,0,0,1, 12'h020, 12'h010, 1,0, 3'b101));
        tbl.push_back(mk(0,0,0,0,1, 12'h020, 12'h020, 1,0, 3'b111));
        tbl.push_back(mk(0,0,0,0,1, 12'h020, 12'h000, 0,1, 3'b101));
        tbl.push_back(mk(0,0,0,0,1, 12'h020, 12'h000, 0,0, 3'b101));

        rst = 1'b1; clr = 1'b0; load_max = 1'b0; max_count = '0;
        continuous = 1'b0; start = 1'b0; step = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("rst_counter", 32'(counter), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_dim_start", 32'(dim_start), 32'h7);
        check("rst_dim_end", 32'(dim_end), 32'h0);
        check("rst_dim_last", 32'(dim_last), 32'h0);
        check("rst_all_end", 32'(all_end), 32'h0);

        // Reset maxima are 15: dim0 reaches its end after 15 steps.
        tick();
        start = 1'b1; tick(); start = 1'b0;
        step = 1'b1;
        repeat (15) tick();
        step = 1'b0;
        check("max15_counter", 32'(counter), 32'h00f);
        check("max15_dim_end", 32'(dim_end), 32'h1);
        check("max15_busy", 32'(busy), 32'h1);
        clr = 1'b1; tick(); clr = 1'b0;
        check("clr_counter", 32'(counter), 32'h0);
        check("clr_busy", 32'(busy), 32'h0);

        // One-shot odometer, max {2,1,3}: 24 steps per iteration.
        load_max = 1'b1; max_count = 12'h213; tick(); load_max = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        check("odo_start_busy", 32'(busy), 32'h1);
        check("odo_start_counter", 32'(counter), 32'h0);
        step = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            tick();
            d0 = (i % 24) % 4;
            d1 = ((i % 24) / 4) % 2;
            d2 = ((i % 24) / 8) % 3;
            exp_cnt = {4'(d2), 4'(d1), 4'(d0)};
            check("odo_counter", 32'(counter), 32'(exp_cnt));
            check("odo_busy", 32'(busy), (i < 24) ? 32'h1 : 32'h0);
            check("odo_done", 32'(done), (i == 24) ? 32'h1 : 32'h0);
        end
        step = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        check("b2b_busy", 32'(busy), 32'h1);
        check("b2b_done", 32'(done), 32'h0);
        check("b2b_counter", 32'(counter), 32'h0);
        clr = 1'b1; tick(); clr = 1'b0;

        // Table-driven vectors.
        foreach (tbl[i]) begin
            clr = tbl[i].clr; load_max = tbl[i].ld; start = tbl[i].start;
            continuous = tbl[i].cont; step = tbl[i].step; max_count = tbl[i].maxc;
            tick();
            check($sformatf("tbl%0d_counter", i), 32'(counter), 32'(tbl[i].cnt));
            check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            check($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].done));
            check($sformatf("tbl%0d_dim_end", i), 32'(dim_end), 32'(tbl[i].dend));
        end
        clr = 1'b0; load_max = 1'b0; start = 1'b0; continuous = 1'b0; step = 1'b0;

        // start together with load_max in idle: load only.
        load_max = 1'b1; start = 1'b1; max_count = 12'h333; tick();
        load_max = 1'b0; start = 1'b0;
        check("ldstart_busy", 32'(busy), 32'h0);
        check("ldstart_dim_end", 32'(dim_end), 32'h0);
        check("ldstart_dim_start", 32'(dim_start), 32'h7);
        start = 1'b1; tick(); start = 1'b0;
        step = 1'b1; repeat (2) tick(); step = 1'b0;
        check("pri_counter", 32'(counter), 32'h002);
        // load_max while busy is ignored.
        load_max = 1'b1; max_count = 12'h000; tick(); load_max = 1'b0;
        check("ldbusy_counter", 32'(counter), 32'h002);
        check("ldbusy_dim_end", 32'(dim_end), 32'h0);
        // start while busy is ignored.
        start = 1'b1; tick(); start = 1'b0;
        check("startbusy_counter", 32'(counter), 32'h002);
        check("startbusy_busy", 32'(busy), 32'h1);
        check("startbusy_dim_last", 32'(dim_last), 32'h1);

        // Async reset mid-count at {1,0,2}.
        step = 1'b1; repeat (16) tick(); step = 1'b0;
        check("mid_counter", 32'(counter), 32'h102);
        #2 rst = 1'b1;
        #1;
        check("arst_counter", 32'(counter), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_done", 32'(done), 32'h0);
        check("arst_dim_start", 32'(dim_start), 32'h7);
        tick();
        rst = 1'b0;
        step = 1'b1; repeat (3) tick(); step = 1'b0;
        check("post_rst_busy", 32'(busy), 32'h0);
        check("post_rst_counter", 32'(counter), 32'h0);
        check("post_rst_dim_last", 32'(dim_last), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_loop_counter

// File: doc/loop_counter.md
# loop_counter

Parametrised nested (odometer-style) loop counter that generalises the single-dimension `countern` to NDIM chained dimensions. Each dimension has a run-time loadable maximum, and a start/done sequencing FSM supports one-shot and continuous modes. It drives lane/row/round iteration in the sponge datapath, so controllers can replace hand-chained counters with one block.

## Interface
- NDIM, 3, number of chained dimensions; dimension 0 is fastest.
- WIDTH, 8, bits per dimension counter and per maximum.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clr  in  1  synchronous abort: FSM to IDLE, all counters to 0, maxima kept.
- load_max  in  1  load `max_count` into all per-dimension maxima.
- max_count  in  NDIM*WIDTH  packed maxima; slice [k*WIDTH +: WIDTH] belongs to dimension k.
- continuous  in  1  mode, sampled at start: 0 = one-shot, 1 = wrap and keep running.
- start  in  1  begin an iteration from all-zero counters.
- step  in  1  advance one position; ignored unless busy.
- counter  out  NDIM*WIDTH  packed current counters, same slicing as `max_count`.
- dim_start  out  NDIM  counter[k] == 0.
- dim_last  out  NDIM  counter[k] == max[k] - 1, WIDTH-bit modular.
- dim_end  out  NDIM  counter[k] == max[k].
- all_end  out  1  AND of dim_end.
- busy  out  1  FSM in RUN.
- done  out  1  one-cycle registered pulse after the final step of an iteration.

## Operation
- FSM has two states, IDLE and RUN. Reset state is IDLE.
- Priority, highest first: rst, clr, load_max, start, step.
- load_max is honoured only in IDLE; it is ignored while busy. It loads the maxima and clears the counters. Any start in the same cycle is dropped.
- start in IDLE clears the counters, latches `continuous`, and goes to RUN. start while busy is ignored.
- step in RUN:
  - Dimension 0 increments.
  - Dimension k increments only when step is high and every dimension j<k is at dim_end.
  - A dimension at dim_end that is due to increment wraps to 0.
- Final step means step is high while all_end is high. On the final step all counters wrap to 0 and done pulses on the next cycle. Then:
  - one-shot: FSM returns to IDLE.
  - continuous: FSM stays in RUN and done pulses once per full iteration.
- One iteration is prod(max[k]+1) steps.
- A dimension whose max is 0 is permanently at dim_end and passes the carry through on every step.
- Counters hold their value when step is low, including in IDLE.
- dim_* and all_end are combinational from the registered counters and maxima. They are valid in any state.

## Timing
- Reset values:
  - counters 0; maxima all-ones.
  - busy 0, done 0.
  - dim_start all 1; dim_end all 0; dim_last all 0; all_end 0.
- start at edge n: busy is high after edge n and the counters read 0. step is accepted from the cycle after start.
- step sampled at edge n: the new counter value is visible after edge n. Throughput is one position per cycle.
- Final step at edge n: counters are 0 and done is 1 after edge n. In one-shot mode busy is 0 after edge n. done deasserts after edge n+1.
- A back-to-back start in the cycle following one-shot done is accepted.
- clr mid-run: after the edge busy is 0, done is 0, and the counters are 0. No done pulse is produced.
- rst mid-run: immediate return to the reset values. Maxima revert to all-ones.

## Structure
- Shared package `loop_counter_pkg`: `lc_state_e` {IDLE, RUN}.
- Sub-module `loop_counter_dim`: one WIDTH-bit counter with max register, carry-in/carry-out and dim_* flags. It is instantiated NDIM times in a generate loop, with carry_out[k] = carry_in[k] & dim_end[k].
- The top level holds the FSM, the continuous latch, and the registered done.

## Test plan
- Reset defaults, NDIM=3, WIDTH=4: release rst -> counters 0, busy 0, done 0, dim_start=3'b111, all maxima 15.
- One-shot odometer: load_max with max={dim2=2, dim1=1, dim0=3}, start, step held high -> sequence 000,001,002,003,010,...,213. Exactly 24 steps, done on the cycle after the 24th, busy drops with it, counters back to 000.
- Continuous with a stalled step: max={1,1,1}, continuous=1, step toggling every other cycle -> counters advance only on step. done pulses after each 8th accepted step, busy stays high, clr ends the run with no done.
- Zero maxima: max={0,2,0} -> dims 0 and 2 always dim_end, dim1 counts 0,1,2, done after 3 steps.
- Priority and ignore rules: load_max while busy -> maxima unchanged. start+load_max together in IDLE -> load only, busy stays 0. start while busy -> no effect on the counters.
- Async reset at mid-count {1,0,2}, asserted between edges -> outputs go to the reset values without waiting for a clock edge. The run does not resume after release.
